// File: rtl/image_mean_divide.sv
// Divides four Bayer-channel sums by the pixel count with one shared serial restoring divider.
// Latency 4*ACCUM_WIDTH+1 cycles start to mean_valid (1 cycle when count==0); start while busy is dropped and flagged.
module image_mean_divide #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12,
    parameter int ACCUM_WIDTH    = NUM_ROWS_WIDTH + NUM_COLS_WIDTH + PIXEL_WIDTH - 2,
    parameter int COUNT_WIDTH    = NUM_ROWS_WIDTH + NUM_COLS_WIDTH - 2
) (
    input  logic                   pixclk,
    input  logic                   resetb,
    input  logic                   start,
    input  logic [ACCUM_WIDTH-1:0] accum00,
    input  logic [ACCUM_WIDTH-1:0] accum01,
    input  logic [ACCUM_WIDTH-1:0] accum10,
    input  logic [ACCUM_WIDTH-1:0] accum11,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [PIXEL_WIDTH-1:0] target,
    output logic [PIXEL_WIDTH-1:0] mean00,
    output logic [PIXEL_WIDTH-1:0] mean01,
    output logic [PIXEL_WIDTH-1:0] mean10,
    output logic [PIXEL_WIDTH-1:0] mean11,
    output logic [PIXEL_WIDTH-1:0] mean_luma,
    output logic [PIXEL_WIDTH:0]   ae_error,
    output logic                   mean_valid,
    output logic                   zero_count,
    output logic                   overrun,
    output logic                   busy
);
    localparam int PW = PIXEL_WIDTH;
    localparam int AW = ACCUM_WIDTH;
    localparam int CW = COUNT_WIDTH;
    localparam int BW = $clog2(AW);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0][AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          target_q, target_d;
    logic [1:0]             chan_q, chan_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]          rem_q, rem_d;
    logic [AW-1:0]          quo_q, quo_d;
    logic [3:0][PW-1:0]     res_q, res_d;
    logic [3:0][PW-1:0]     mean_q, mean_d;
    logic [PW-1:0]          luma_q, luma_d;
    logic [PW:0]            ae_q, ae_d;
    logic                   valid_q, valid_d;
    logic                   zero_q, zero_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [BW-1:0]          bit_idx;
    logic [CW:0]            trial;
    logic [CW:0]            diff;
    logic                   q_bit;
    logic [AW-1:0]          quo_next;
    logic [PW-1:0]          quo_sat;

    always_comb begin
        bit_idx  = BW'(AW - 1) - bit_cnt_q;
        trial    = {rem_q, acc_q[chan_q][bit_idx]};
        diff     = trial - {1'b0, count_q};
        q_bit    = (trial >= {1'b0, count_q});
        quo_next = {quo_q[AW-2:0], q_bit};
        quo_sat  = (|quo_next[AW-1:PW]) ? {PW{1'b1}} : quo_next[PW-1:0];
    end

    logic                   load_out;
    logic [3:0][PW-1:0]     new_mean;
    logic [PW-1:0]          new_tgt;
    logic [PW+1:0]          luma_sum;
    logic [PW-1:0]          new_luma;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        target_d  = target_q;
        chan_d    = chan_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_d     = res_q;
        mean_d    = mean_q;
        luma_d    = luma_q;
        ae_d      = ae_q;
        valid_d   = 1'b0;
        zero_d    = zero_q;
        overrun_d = overrun_q;
        busy_d    = busy_q;
        load_out  = 1'b0;
        new_mean  = '0;
        new_tgt   = target_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = {accum11, accum10, accum01, accum00};
                    count_d   = count;
                    target_d  = target;
                    chan_d    = '0;
                    bit_cnt_d = '0;
                    rem_d     = '0;
                    quo_d     = '0;
                    overrun_d = 1'b0;
                    zero_d    = 1'b0;
                    busy_d    = 1'b1;
                    if (count == '0) begin
                        // No pixels: skip the divider and publish zero means now.
                        zero_d   = 1'b1;
                        load_out = 1'b1;
                        new_tgt  = target;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (start) overrun_d = 1'b1;
                rem_d     = q_bit ? diff[CW-1:0] : trial[CW-1:0];
                quo_d     = quo_next;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BW'(AW - 1)) begin
                    bit_cnt_d      = '0;
                    rem_d          = '0;
                    quo_d          = '0;
                    res_d[chan_q]  = quo_sat;
                    chan_d         = chan_q + 1'b1;
                    if (chan_q == 2'd3) begin
                        new_mean = res_d;
                        load_out = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (start) overrun_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        luma_sum = {2'b00, new_mean[0]} + {2'b00, new_mean[1]}
                 + {2'b00, new_mean[2]} + {2'b00, new_mean[3]};
        new_luma = luma_sum[PW+1:2];
        if (load_out) begin
            mean_d = new_mean;
            luma_d = new_luma;
            ae_d   = {1'b0, new_tgt} - {1'b0, new_luma};
        end
    end

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            target_q  <= '0;
            chan_q    <= '0;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_q     <= '0;
            mean_q    <= '0;
            luma_q    <= '0;
            ae_q      <= '0;
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            target_q  <= target_d;
            chan_q    <= chan_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_q     <= res_d;
            mean_q    <= mean_d;
            luma_q    <= luma_d;
            ae_q      <= ae_d;
            valid_q   <= valid_d;
            zero_q    <= zero_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign mean00     = mean_q[0];
    assign mean01     = mean_q[1];
    assign mean10     = mean_q[2];
    assign mean11     = mean_q[3];
    assign mean_luma  = luma_q;
    assign ae_error   = ae_q;
    assign mean_valid = valid_q;
    assign zero_count = zero_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
endmodule
